// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned OPCODE_W    = 10;
    localparam int unsigned OFFSET_W    = 19;
    localparam int unsigned RETIRE_W    = 16;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/ifu_pc_next.sv
// Combinational next-pc adder: sequential step or signed word-offset branch.
module ifu_pc_next
    import ifu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 16
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                branch_taken,
    input  logic [OFFSET_W-1:0] branch_offset,
    output logic [PC_WIDTH-1:0] pc_next_c
);

    localparam int unsigned EXT_W = (PC_WIDTH > OFFSET_W) ? PC_WIDTH : OFFSET_W;

    logic [EXT_W-1:0]    offset_ext;
    logic [PC_WIDTH-1:0] delta;

    // Sign-extend the word offset, scale to bytes; the add wraps silently.
    always_comb begin
        offset_ext = EXT_W'($signed(branch_offset));
        delta      = branch_taken ? PC_WIDTH'(offset_ext << 2) : PC_WIDTH'(INSTR_BYTES);
        pc_next_c  = pc + delta;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches one instruction at a time, holds it for the controller, advances pc on retire.
// Optional macro IFU_HALT_EN: fetching HALT_WORD parks the unit and raises halted.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned          PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instruction,
    output logic [OPCODE_W-1:0] opcode,
    output logic                instr_valid,
    input  logic                ctrl_done,
    input  logic                branch_taken,
    input  logic [OFFSET_W-1:0] branch_offset,
    output logic [PC_WIDTH-1:0] pc,
    output logic [RETIRE_W-1:0] retired_count
`ifdef IFU_HALT_EN
    ,
    output logic                halted
`endif
);

    ifu_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                imem_req_q, imem_req_d;
    logic                instr_valid_q, instr_valid_d;
    logic [PC_WIDTH-1:0] pc_next_c;
    ifu_state_e          accept_state_c;
`ifdef IFU_HALT_EN
    logic                halted_q, halted_d;
`endif

    ifu_pc_next #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .pc_next_c     (pc_next_c)
    );

    // Where an accepted word sends the FSM.
    always_comb begin
`ifdef IFU_HALT_EN
        accept_state_c = (imem_rdata == HALT_WORD) ? HALT : HOLD;
`else
        accept_state_c = HOLD;
`endif
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = accept_state_c;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = accept_state_c;
                end
            end
            HOLD: begin
                if (ctrl_done) begin
                    pc_d      = pc_next_c;
                    retired_d = retired_q + RETIRE_W'(1);
                    state_d   = REQ;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Flag outputs are registered from the upcoming state.
    always_comb begin
        imem_req_d    = (state_d == REQ);
        instr_valid_d = (state_d == HOLD);
`ifdef IFU_HALT_EN
        halted_d      = (state_d == HALT);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            retired_q     <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef IFU_HALT_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
`ifdef IFU_HALT_EN
            halted_q      <= halted_d;
`endif
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instruction   = instr_q;
    assign opcode        = instr_q[INSTR_W-1 -: OPCODE_W];
    assign instr_valid   = instr_valid_q;
    assign retired_count = retired_q;
`ifdef IFU_HALT_EN
    assign halted        = halted_q;
`endif

endmodule
